// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit:
//   fetch_state_t   - 2-bit FSM state encoding (IDLE, FETCH, HOLD)
//   PC_INCREMENT    - byte distance between consecutive instruction words
//   PC_READ_OFFSET  - offset of the ARM R15 read value from the fetch address
//   ALIGN_MASK      - clears bits [1:0] so the PC always holds a word address
//   align_addr()    - applies ALIGN_MASK to a redirect target
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_INCREMENT   = 32'd4;
    localparam logic [31:0] PC_READ_OFFSET = 32'd8;
    localparam logic [31:0] ALIGN_MASK     = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_addr(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
// 32-bit program counter with synchronous reset to RESET_VECTOR, parallel load
// and word increment. Priority: reset > load > increment.
// Ports:
//   clk        - clock, state updates on posedge
//   reset      - synchronous, active-high; pc <= RESET_VECTOR
//   load       - load load_value into pc this cycle
//   load_value - value to load (already word aligned by the caller)
//   increment  - advance pc by PC_INCREMENT (wraps modulo 2^32)
//   pc         - current program counter
// -----------------------------------------------------------------------------
module pc_register
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        increment,
    output logic [31:0] pc
);

    // Plain 32-bit addition gives the required wrap from FFFFFFFC to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_VECTOR;
        end else if (load) begin
            pc <= load_value;
        end else if (increment) begin
            pc <= pc + PC_INCREMENT;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: requests one word at a time from instruction memory,
// presents it to decode together with the ARM-style R15 read value (addr + 8)
// and the BL link value (addr + 4), and holds it until decode accepts it.
// Branches and register-file writes to R15 redirect the PC from any state.
// Ports:
//   clk, reset              - clock and synchronous active-high reset
//   stall                   - decode not ready; keep the current instruction
//   branchTaken/Target      - branch redirect request and destination
//   writeToPC/pcWriteData   - R15 write redirect (wins over a branch)
//   imemReq/imemAddr        - instruction memory request and word address
//   imemReady/imemData      - memory response strobe and data
//   instrValid              - instruction/oldPCVal/linkValue are valid
//   instruction             - fetched instruction word
//   oldPCVal                - fetch address + 8
//   linkValue               - fetch address + 4
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        writeToPC,
    input  logic [31:0] pcWriteData,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic        instrValid,
    output logic [31:0] instruction,
    output logic [31:0] oldPCVal,
    output logic [31:0] linkValue
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         redirect;
    logic [31:0]  redirect_target;
    logic         capture;

    assign redirect        = writeToPC | branchTaken;
    assign redirect_target = align_addr(writeToPC ? pcWriteData : branchTarget);

    // A response is only accepted when no redirect arrives in the same cycle;
    // otherwise the word belongs to the abandoned path and is dropped.
    assign capture = (state == FETCH) && imemReady && !redirect;

    pc_register #(
        .RESET_VECTOR(RESET_VECTOR)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load       (redirect),
        .load_value (redirect_target),
        .increment  (capture),
        .pc         (pc)
    );

    // The request is masked by reset so memory never sees a request while
    // the unit is being reinitialised, whatever state it was in.
    assign imemReq  = (state == FETCH) && !reset;
    assign imemAddr = pc;

    // Reset outranks redirect, which outranks the normal FETCH/HOLD flow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            instrValid  <= 1'b0;
            instruction <= 32'h0;
            oldPCVal    <= 32'h0;
            linkValue   <= 32'h0;
        end else if (redirect) begin
            state      <= FETCH;
            instrValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imemReady) begin
                        instruction <= imemData;
                        oldPCVal    <= pc + PC_READ_OFFSET;
                        linkValue   <= pc + PC_INCREMENT;
                        instrValid  <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instrValid <= 1'b0;
                        state      <= FETCH;
                    end
                end
                default: begin
                    state      <= IDLE;
                    instrValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h00000000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  downstream decode/register-file stage not ready to accept instruction.
REQ-005 SHALL have port branchTaken  input  1  branch redirect request this cycle.
REQ-006 SHALL have port branchTarget  input  32  branch destination address.
REQ-007 SHALL have port writeToPC  input  1  register-file write to R15 this cycle.
REQ-008 SHALL have port pcWriteData  input  32  value written to R15.
REQ-009 SHALL have port imemReq  output  1  instruction memory request.
REQ-010 SHALL have port imemAddr  output  32  instruction memory word address.
REQ-011 SHALL have port imemReady  input  1  memory returns imemData this cycle.
REQ-012 SHALL have port imemData  input  32  fetched instruction word.
REQ-013 SHALL have port instrValid  output  1  instruction/oldPCVal/linkValue valid.
REQ-014 SHALL have port instruction  output  32  fetched instruction.
REQ-015 SHALL have port oldPCVal  output  32  instruction address + 8 (ARM R15 read value).
REQ-016 SHALL have port linkValue  output  32  instruction address + 4 (BL return address).

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, HOLD.
REQ-018 IDLE: imemReq=0; next state FETCH unconditionally.
REQ-019 FETCH: imemReq=1, imemAddr=pc; on imemReady with no redirect, capture imemData into instruction, oldPCVal=pc+8, linkValue=pc+4, pc<=pc+4, instrValid<=1, next HOLD; otherwise stay FETCH.
REQ-020 HOLD: imemReq=0, outputs held stable; stall=1 -> stay HOLD; stall=0 -> instruction consumed this cycle, instrValid<=0, next FETCH.
REQ-021 Redirect = writeToPC or branchTaken; writeToPC has priority; target = pcWriteData or branchTarget with bits[1:0] forced to 00.
REQ-022 Redirect in any state: pc<=target, instrValid<=0, next FETCH; any imemData returned in the same cycle is discarded.
REQ-023 Redirect in HOLD squashes the held instruction even if stall=0.
REQ-024 PC arithmetic modulo 2^32: pc 32'hFFFFFFFC advances to 32'h00000000; oldPCVal/linkValue wrap likewise.
REQ-025 Minimum latency: imemReady in cycle N -> instrValid=1 in cycle N+1; next imemReq earliest cycle N+2.
REQ-026 imemAddr and imemReq SHALL not change while in FETCH awaiting imemReady, except on redirect.

Reset
REQ-027 reset=1 at posedge: state<=IDLE, pc<=RESET_VECTOR, instrValid<=0, instruction<=0, oldPCVal<=0, linkValue<=0; imemReq=0 while reset high.
REQ-028 Reset asserted mid-fetch or mid-hold SHALL abort; imemData arriving in that cycle is discarded.
REQ-029 Reset has priority over redirect, stall and imemReady.

Structure
REQ-030 Shared package SHALL hold FSM state enum (2-bit), PC_INCREMENT=4, PC_READ_OFFSET=8, ALIGN_MASK=32'hFFFFFFFC.
REQ-031 SHALL instantiate one sub-module pc_register (32-bit PC with load/increment/reset-vector); FSM and output registers inline.

Verification
REQ-032 Reset release, imemReady=1 always, stall=0 -> imemAddr sequence 0,4,8; instruction words in order; oldPCVal 8,12,16.
REQ-033 stall=1 for 3 cycles in HOLD -> instruction/oldPCVal unchanged, imemReq=0, no PC advance; resumes fetch at next address.
REQ-034 branchTaken=1, branchTarget=32'h00000103, simultaneous with imemReady -> data discarded, next imemAddr=32'h00000100.
REQ-035 writeToPC=1, pcWriteData=32'h200 and branchTaken=1, branchTarget=32'h300 same cycle -> next imemAddr=32'h200.
REQ-036 RESET_VECTOR=32'hFFFFFFFC -> first fetch oldPCVal=32'h00000004, linkValue=32'h00000000, second imemAddr=0.
REQ-037 reset asserted during FETCH with imemReady=1 -> instrValid stays 0, next imemAddr=RESET_VECTOR.
